// File: rtl/multi_cycle_control_unit.sv
// Control unit for a multi-cycle MIPS-subset CPU: an eight-state FSM plus
// combinational decode of every datapath control from state and opcode.
module multi_cycle_control_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic [1:0] PCSrc,
    output logic [1:0] RegDst,
    output logic [2:0] ALUOp,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_XORI  = 6'b010100;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLTZ  = 6'b110010;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_e state_q, state_d;

    logic       isRType, isIType, isLoad, isStore, isBranch;
    logic       isJ, isJr, isJal, isHalt, isSll, zeroExt;
    logic [2:0] aluOpAl;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Opcode classification; anything not matched here falls through as a NOP.
    always_comb begin
        isRType  = 1'b0;
        isIType  = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        isBranch = 1'b0;
        isJ      = 1'b0;
        isJr     = 1'b0;
        isJal    = 1'b0;
        isHalt   = 1'b0;
        isSll    = 1'b0;
        zeroExt  = 1'b0;
        aluOpAl  = 3'b000;
        case (opcode)
            OP_ADD:   begin isRType = 1'b1; aluOpAl = 3'b000; end
            OP_SUB:   begin isRType = 1'b1; aluOpAl = 3'b001; end
            OP_AND:   begin isRType = 1'b1; aluOpAl = 3'b100; end
            OP_OR:    begin isRType = 1'b1; aluOpAl = 3'b011; end
            OP_SLL:   begin isRType = 1'b1; isSll = 1'b1; aluOpAl = 3'b010; end
            OP_ADDIU: begin isIType = 1'b1; aluOpAl = 3'b000; end
            OP_ANDI:  begin isIType = 1'b1; zeroExt = 1'b1; aluOpAl = 3'b100; end
            OP_ORI:   begin isIType = 1'b1; zeroExt = 1'b1; aluOpAl = 3'b011; end
            OP_XORI:  begin isIType = 1'b1; zeroExt = 1'b1; aluOpAl = 3'b111; end
            OP_SLTI:  begin isIType = 1'b1; aluOpAl = 3'b110; end
            OP_LW:    isLoad   = 1'b1;
            OP_SW:    isStore  = 1'b1;
            OP_BEQ,
            OP_BNE,
            OP_BLTZ:  isBranch = 1'b1;
            OP_J:     isJ      = 1'b1;
            OP_JR:    isJr     = 1'b1;
            OP_JAL:   isJal    = 1'b1;
            OP_HALT:  isHalt   = 1'b1;
            default:  ;
        endcase
    end

    // Next state and all controls; IF keeps opcode-derived controls quiet so
    // the unit looks identical during and right after reset.
    always_comb begin
        state_d   = state_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        PCSrc     = 2'b00;
        RegDst    = 2'b00;
        ALUOp     = 3'b000;

        if (state_q != S_IF) begin
            ALUSrcA   = isSll;
            ALUSrcB   = isIType | isLoad | isStore;
            ExtSel    = ~zeroExt;
            WrRegDSrc = ~isJal;
            if (isRType) begin
                RegDst = 2'b10;
            end else if (isIType || isLoad) begin
                RegDst = 2'b01;
            end
        end

        case (state_q)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                if (isHalt) begin
                    state_d = S_ID;
                end else if (isBranch) begin
                    state_d = S_EXE_BR;
                end else if (isLoad || isStore) begin
                    state_d = S_EXE_LS;
                end else if (isRType || isIType) begin
                    state_d = S_EXE_AL;
                end else begin
                    // Jumps finish here; undefined opcodes retire as NOPs.
                    state_d = S_IF;
                    PCWre   = 1'b1;
                    RegWre  = isJal;
                    if (isJr) begin
                        PCSrc = 2'b10;
                    end else if (isJ || isJal) begin
                        PCSrc = 2'b11;
                    end
                end
            end
            S_EXE_AL: begin
                ALUOp   = aluOpAl;
                state_d = S_WB_AL;
            end
            S_WB_AL: begin
                RegWre  = 1'b1;
                PCWre   = 1'b1;
                state_d = S_IF;
            end
            S_EXE_BR: begin
                ALUOp   = 3'b001;
                PCWre   = 1'b1;
                if (((opcode == OP_BEQ) && zero) ||
                    ((opcode == OP_BNE) && !zero) ||
                    ((opcode == OP_BLTZ) && sign)) begin
                    PCSrc = 2'b01;
                end
                state_d = S_IF;
            end
            S_EXE_LS: begin
                ALUOp   = 3'b000;
                state_d = S_MEM;
            end
            S_MEM: begin
                if (isLoad) begin
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                    state_d   = S_WB_L;
                end else begin
                    mWR     = isStore;
                    PCWre   = isStore;
                    state_d = S_IF;
                end
            end
            S_WB_L: begin
                RegWre    = 1'b1;
                DBDataSrc = isLoad;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench: each instruction's state path and per-state controls
// are predicted from the instruction class, then compared step by step.
module tb_multi_cycle_control_unit;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_XORI  = 6'b010100;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLTZ  = 6'b110010;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXE_LS = 3'd2, ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB_L = 3'd4, ST_EXE_BR = 3'd5, ST_EXE_AL = 3'd6, ST_WB_AL = 3'd7;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero, sign;
    logic       PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    int errors = 0;
    int checks = 0;
    logic [5:0] defOps [19];

    multi_cycle_control_unit dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
        .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp), .state(state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit isDefined(input logic [5:0] op);
        for (int i = 0; i < 19; i++) begin
            if (defOps[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] aluFor(input logic [5:0] op);
        case (op)
            OP_SUB:          return 3'b001;
            OP_SLL:          return 3'b010;
            OP_OR, OP_ORI:   return 3'b011;
            OP_AND, OP_ANDI: return 3'b100;
            OP_XORI:         return 3'b111;
            OP_SLTI:         return 3'b110;
            default:         return 3'b000;
        endcase
    endfunction

    // Expected controls for one step, derived from instruction class and step position.
    task automatic checkStep(input logic [5:0] op, input logic z, input logic s,
                             input logic [2:0] st, input bit last, input string name);
        bit rType, iType, writesReg, taken, notIf;
        logic [1:0] expPcSrc, expRegDst;
        logic [2:0] expAlu;
        string pre;
        rType     = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL};
        iType     = op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI};
        writesReg = rType || iType || op == OP_LW || op == OP_JAL;
        taken     = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s);
        notIf     = (st != ST_IF);
        expPcSrc  = 2'b00;
        if (st == ST_EXE_BR && taken) expPcSrc = 2'b01;
        if (st == ST_ID && (op == OP_J || op == OP_JAL)) expPcSrc = 2'b11;
        if (st == ST_ID && op == OP_JR) expPcSrc = 2'b10;
        expRegDst = 2'b00;
        if (notIf && rType) expRegDst = 2'b10;
        else if (notIf && (iType || op == OP_LW)) expRegDst = 2'b01;
        expAlu = 3'b000;
        if (st == ST_EXE_BR) expAlu = 3'b001;
        if (st == ST_EXE_AL) expAlu = aluFor(op);
        pre = $sformatf("%s[op=%06b st=%0d]", name, op, st);
        checkOutput({pre, " state"},     32'(state),     32'(st));
        checkOutput({pre, " PCWre"},     32'(PCWre),     32'(last && op != OP_HALT));
        checkOutput({pre, " IRWre"},     32'(IRWre),     32'(!notIf));
        checkOutput({pre, " InsMemRW"},  32'(InsMemRW),  32'(!notIf));
        checkOutput({pre, " RegWre"},    32'(RegWre),    32'(last && writesReg));
        checkOutput({pre, " mRD"},       32'(mRD),       32'(op == OP_LW && st == ST_MEM));
        checkOutput({pre, " mWR"},       32'(mWR),       32'(op == OP_SW && st == ST_MEM));
        checkOutput({pre, " DBDataSrc"}, 32'(DBDataSrc), 32'(op == OP_LW && (st == ST_MEM || st == ST_WB_L)));
        checkOutput({pre, " ALUSrcA"},   32'(ALUSrcA),   32'(notIf && op == OP_SLL));
        checkOutput({pre, " ALUSrcB"},   32'(ALUSrcB),   32'(notIf && (iType || op == OP_LW || op == OP_SW)));
        checkOutput({pre, " ExtSel"},    32'(ExtSel),    32'(notIf && !(op inside {OP_ANDI, OP_ORI, OP_XORI})));
        checkOutput({pre, " WrRegDSrc"}, 32'(WrRegDSrc), 32'(notIf && op != OP_JAL));
        checkOutput({pre, " PCSrc"},     32'(PCSrc),     32'(expPcSrc));
        checkOutput({pre, " RegDst"},    32'(RegDst),    32'(expRegDst));
        checkOutput({pre, " ALUOp"},     32'(ALUOp),     32'(expAlu));
    endtask

    // Runs one non-halt instruction from IF back to IF, checking every step.
    task automatic applyStimulus(input logic [5:0] op, input logic z, input logic s, input string name);
        logic [2:0] path[$];
        path.push_back(ST_IF);
        path.push_back(ST_ID);
        if (op inside {OP_BEQ, OP_BNE, OP_BLTZ}) begin
            path.push_back(ST_EXE_BR);
        end else if (op == OP_LW) begin
            path.push_back(ST_EXE_LS); path.push_back(ST_MEM); path.push_back(ST_WB_L);
        end else if (op == OP_SW) begin
            path.push_back(ST_EXE_LS); path.push_back(ST_MEM);
        end else if (isDefined(op) && !(op inside {OP_J, OP_JR, OP_JAL})) begin
            path.push_back(ST_EXE_AL); path.push_back(ST_WB_AL);
        end
        opcode = op;
        zero   = z;
        sign   = s;
        for (int k = 0; k < path.size(); k++) begin
            checkStep(op, z, s, path[k], (k != 0) && (k == path.size() - 1), name);
            @(posedge CLK); #1;
        end
        checkOutput({name, " returnIF"}, 32'(state), 32'(ST_IF));
    endtask

    initial begin
        logic [5:0] op;
        defOps = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_OR, OP_XORI,
                   OP_SLL, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J,
                   OP_JR, OP_JAL, OP_HALT};
        Reset  = 1'b0;
        opcode = OP_JAL;
        zero   = 1'b1;
        sign   = 1'b1;
        #3;
        checkStep(OP_JAL, 1'b1, 1'b1, ST_IF, 1'b0, "inReset");
        @(negedge CLK); #1;
        checkStep(OP_JAL, 1'b1, 1'b1, ST_IF, 1'b0, "inResetEdge");
        Reset = 1'b1;
        #1;

        applyStimulus(OP_ADD,  1'b0, 1'b0, "add");
        applyStimulus(OP_LW,   1'b0, 1'b0, "lw");
        applyStimulus(OP_SW,   1'b1, 1'b0, "sw");
        applyStimulus(OP_BEQ,  1'b1, 1'b0, "beqTaken");
        applyStimulus(OP_BEQ,  1'b0, 1'b1, "beqNotTaken");
        applyStimulus(OP_BNE,  1'b0, 1'b0, "bneTaken");
        applyStimulus(OP_BLTZ, 1'b0, 1'b1, "bltzTaken");
        applyStimulus(OP_BLTZ, 1'b1, 1'b0, "bltzNotTaken");
        applyStimulus(OP_JAL,  1'b0, 1'b0, "jal");
        applyStimulus(OP_JR,   1'b0, 1'b0, "jr");
        applyStimulus(OP_J,    1'b0, 1'b0, "j");
        applyStimulus(6'b001111, 1'b1, 1'b1, "undefined");
        applyStimulus(OP_XORI, 1'b0, 1'b0, "xori");
        applyStimulus(OP_SLL,  1'b0, 1'b0, "sll");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (isDefined(op));
            end else begin
                op = defOps[$urandom_range(0, 17)];
            end
            applyStimulus(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        // Reset arriving while sw sits in MEM must kill the store immediately.
        opcode = OP_SW;
        zero   = 1'b0;
        sign   = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        checkOutput("swMem state", 32'(state), 32'(ST_MEM));
        checkOutput("swMem mWR",   32'(mWR),   32'd1);
        Reset = 1'b0;
        #1;
        checkOutput("swAbort state", 32'(state), 32'(ST_IF));
        checkOutput("swAbort mWR",   32'(mWR),   32'd0);
        checkOutput("swAbort PCWre", 32'(PCWre), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        applyStimulus(OP_ADD, 1'b0, 1'b0, "afterAbort");

        opcode = OP_HALT;
        @(posedge CLK); #1;
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("halt%0d state", c),  32'(state),  32'(ST_ID));
            checkOutput($sformatf("halt%0d PCWre", c),  32'(PCWre),  32'd0);
            checkOutput($sformatf("halt%0d RegWre", c), 32'(RegWre), 32'd0);
            @(posedge CLK); #1;
        end
        Reset = 1'b0;
        #1;
        checkOutput("haltReset state", 32'(state), 32'(ST_IF));
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        applyStimulus(OP_ORI, 1'b0, 1'b0, "afterHalt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are named CLK and Reset.
REQ-002 SHALL have port CLK, input, 1 bit: rising-edge clock for the state register.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 SHALL have ports zero and sign, input, 1 bit each: ALU result flags from the current cycle.
REQ-006 SHALL have outputs PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc and WrRegDSrc, 1 bit each.
REQ-007 SHALL have outputs PCSrc (2 bits: 00 = PC+4, 01 = branch target, 10 = rs, 11 = jump target) and RegDst (2 bits: 00 = $31, 01 = rt, 10 = rd).
REQ-008 SHALL have output ALUOp, 3 bits: 000 add, 001 sub, 010 sll, 011 or, 100 and, 101 sltu, 110 slt, 111 xor.
REQ-009 SHALL have output state, 3 bits: current FSM state, for debug.

Function
REQ-010 SHALL use opcodes add 000000, sub 000001, addiu 000010, and 010001, andi 010000, ori 010010, or 010011, xori 010100, sll 011000, slti 011100, sw 100110, lw 100111, beq 110000, bne 110001, bltz 110010, j 111000, jr 111001, jal 111010 and halt 111111.
REQ-011 SHALL encode states as IF 000, ID 001, EXE_LS 010, MEM 011, WB_L 100, EXE_BR 101, EXE_AL 110 and WB_AL 111.
REQ-012 SHALL make these transitions: IF->ID; ID->EXE_BR for beq/bne/bltz; ID->EXE_LS for sw/lw; ID->IF for j/jr/jal; ID->ID for halt; ID->EXE_AL otherwise.
REQ-013 SHALL make these further transitions: EXE_AL->WB_AL->IF; EXE_BR->IF; EXE_LS->MEM; MEM->IF for sw; MEM->WB_L for lw; WB_L->IF.
REQ-014 SHALL treat any undefined opcode as a NOP: ID->IF with every write enable 0 except PCWre.
REQ-015 SHALL derive all outputs combinationally from state and opcode, and from zero/sign in EXE_BR.
REQ-016 SHALL assert IRWre=1 and InsMemRW=1 only in IF.
REQ-017 SHALL assert PCWre=1 only in the final state of an instruction: WB_AL, WB_L, EXE_BR, MEM (sw only), and ID (j/jr/jal/undefined opcodes).
REQ-018 SHALL hold PCWre=0 throughout halt, so the PC freezes with no further state change.
REQ-019 SHALL set PCSrc in EXE_BR: 01 when (beq and zero=1), (bne and zero=0) or (bltz and sign=1), else 00.
REQ-020 SHALL set PCSrc to 11 for j/jal, 10 for jr, and 00 in all other cases.
REQ-021 SHALL drive ALUOp 001 in EXE_BR, 000 in EXE_LS, and per opcode in EXE_AL (addiu=000, andi=100, ori=011, xori=111, slti=110).
REQ-022 SHALL set ALUSrcA=1 only for sll, and ALUSrcB=1 for addiu/andi/ori/xori/slti/lw/sw.
REQ-023 SHALL set ExtSel=0 (zero-extend) for andi/ori/xori, and 1 otherwise.
REQ-024 SHALL assert RegWre=1 in WB_AL and WB_L, and in ID for jal; RegWre SHALL be 0 for jal in every other state.
REQ-025 SHALL set RegDst to 10 for R-type ops, 01 for I-type/lw, and 00 for jal; WrRegDSrc SHALL be 0 only for jal.
REQ-026 SHALL set mRD=1 in MEM for lw and mWR=1 in MEM for sw; both are 0 elsewhere.
REQ-027 SHALL set DBDataSrc=1 in MEM and WB_L for lw, and 0 otherwise.

Reset
REQ-028 SHALL force state to IF asynchronously while Reset=0, regardless of CLK.
REQ-029 SHALL, during and immediately after reset, output IRWre=1, InsMemRW=1 and all other 1-bit outputs 0, with PCSrc=00, RegDst=00 and ALUOp=000.
REQ-030 SHALL abort any in-flight instruction on reset assertion mid-instruction, with no register or memory write in the cycle Reset is low.
REQ-031 SHALL take its first transition (IF->ID) on the first CLK rising edge after Reset deasserts.

Verification
REQ-032 Bench SHALL check: opcode=000000 -> states IF, ID, EXE_AL, WB_AL, IF; RegWre=1 and PCWre=1 only in WB_AL; RegDst=10.
REQ-033 Bench SHALL check: lw (100111) -> states 000, 001, 010, 011, 100, 000; mRD=1 in MEM; RegWre=1 in WB_L; sw (100110) -> mWR=1 and PCWre=1 in MEM, then IF.
REQ-034 Bench SHALL check: beq with zero=1 in EXE_BR -> PCSrc=01 and PCWre=1; beq with zero=0 -> PCSrc=00; bltz with sign=1 -> PCSrc=01.
REQ-035 Bench SHALL check: jal -> in ID, PCSrc=11, RegDst=00, WrRegDSrc=0, RegWre=1 and PCWre=1, then IF; jr -> PCSrc=10.
REQ-036 Bench SHALL check: halt -> state stays 001 for 10 cycles with PCWre=0 and RegWre=0.
REQ-037 Bench SHALL check: Reset pulled low mid-MEM of sw -> state=000 and mWR=0 immediately, without a clock edge.
